// File: rtl/ysyx_23060020_mem_resp_pkg.sv
// Shared types and constants for the multi-cycle memory responder.
package ysyx_23060020_mem_resp_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam int CNT_W = 4;

  localparam logic [31:0] DEFAULT_ADDR_BASE = 32'h8000_0000;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

endpackage

// File: rtl/ysyx_23060020_sram_array.sv
// Word-organised storage with per-byte write enables and a combinational read port.
// Contents are deliberately not reset.
module ysyx_23060020_sram_array #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           wen,
  input  logic [$clog2(DEPTH_WORDS)-1:0] waddr,
  input  logic [3:0]                     wmask,
  input  logic [31:0]                    wdata,
  input  logic [$clog2(DEPTH_WORDS)-1:0] raddr,
  output logic [31:0]                    rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Byte-lane write: only lanes with their mask bit set are updated.
  always_ff @(posedge clk) begin
    if (wen) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask[i]) begin
          mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ysyx_23060020_mem_resp.sv
// Memory-side responder: accepts one request, waits LATENCY cycles, then
// presents read data or write completion until the requester takes it.
//
// state  | meaning
// S_IDLE | ready for a request; writes commit at the acceptance edge
// S_WAIT | counting down the programmed access latency
// S_RESP | response held on rsp_* until rsp_valid && rsp_ready
module ysyx_23060020_mem_resp
  import ysyx_23060020_mem_resp_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = DEFAULT_ADDR_BASE,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int               IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [31:0]      SPAN     = 32'(4 * DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] lat_idx;
  logic             lat_wen;
  logic             lat_err;
  rsp_t             rsp_q;
  rsp_t             rsp_cap;

  logic [31:0]      offset;
  logic             in_range;
  logic [IDX_W-1:0] req_idx;
  logic [IDX_W-1:0] rd_idx;
  logic [31:0]      rd_word;
  logic             accept;
  logic             cap_wen;
  logic             cap_err;

  // Unsigned subtraction wraps addresses below the base to huge offsets,
  // so a single compare covers both ends of the window.
  assign offset    = req_addr - ADDR_BASE;
  assign in_range  = offset < SPAN;
  assign req_idx   = offset[IDX_W+1:2];

  assign req_ready = (state == S_IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  // With zero latency the response is captured at the acceptance edge,
  // so the live request drives the read port and the payload select.
  assign rd_idx    = (state == S_IDLE) ? req_idx : lat_idx;
  assign cap_wen   = (state == S_IDLE) ? req_wen : lat_wen;
  assign cap_err   = (state == S_IDLE) ? !in_range : lat_err;

  // Payload to load on entry to S_RESP: data only for in-range reads.
  always_comb begin
    rsp_cap       = '0;
    rsp_cap.err   = cap_err;
    rsp_cap.rdata = (cap_wen || cap_err) ? 32'h0 : rd_word;
  end

  ysyx_23060020_sram_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_sram (
    .clk  (clk),
    .wen  (accept && req_wen && in_range),
    .waddr(req_idx),
    .wmask(req_wmask),
    .wdata(req_wdata),
    .raddr(rd_idx),
    .rdata(rd_word)
  );

  // Transaction FSM with latency down-counter and registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      lat_idx   <= '0;
      lat_wen   <= 1'b0;
      lat_err   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_q     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            lat_idx <= req_idx;
            lat_wen <= req_wen;
            lat_err <= !in_range;
            if (LATENCY == 0) begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_q     <= rsp_cap;
            end else begin
              state <= S_WAIT;
              cnt   <= CNT_LOAD;
            end
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_q     <= rsp_cap;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign rsp_rdata = rsp_q.rdata;
  assign rsp_err   = rsp_q.err;

endmodule

// File: tb/tb_ysyx_23060020_mem_resp.sv
// Bench for the memory responder: two builds (LATENCY=2 and LATENCY=0)
// driven with directed and random transactions, checked against a word-map model.
module tb_ysyx_23060020_mem_resp;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] SPAN  = 32'(4 * DEPTH);

  logic             clk = 1'b0;
  logic [1:0]       rst;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       req_wen;
  logic [1:0][31:0] req_addr;
  logic [1:0][31:0] req_wdata;
  logic [1:0][3:0]  req_wmask;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [1:0][31:0] rsp_rdata;
  logic [1:0]       rsp_err;

  int n_tests = 0;
  int n_fail  = 0;

  // reference memory: key = unit*DEPTH + word index
  logic [31:0] mdl [int];

  always #5 clk = ~clk;

  ysyx_23060020_mem_resp #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(2)) dut_l2 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_wen(req_wen[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .req_wmask(req_wmask[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  ysyx_23060020_mem_resp #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(0)) dut_l0 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_wen(req_wen[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .req_wmask(req_wmask[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lat_of(input int u);
    return (u == 0) ? 2 : 0;
  endfunction

  function automatic bit addr_ok(input logic [31:0] a);
    return (a - BASE) < SPAN;
  endfunction

  function automatic int key_of(input int u, input logic [31:0] a);
    return u * DEPTH + int'(((a - BASE) >> 2) % DEPTH);
  endfunction

  // apply a write to the model; returns nothing, out-of-range is a no-op
  task automatic model_write(input int u, input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] wm);
    logic [31:0] w;
    int k;
    if (!addr_ok(a)) return;
    k = key_of(u, a);
    w = mdl.exists(k) ? mdl[k] : 32'h0;
    for (int i = 0; i < 4; i++)
      if (wm[i]) w[8*i +: 8] = wd[8*i +: 8];
    mdl[k] = w;
  endtask

  // one full request/response; stall = cycles of rsp_ready low after rsp_valid
  task automatic txn(input int u, input bit wen, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] wm, input int stall,
                     output logic [31:0] got);
    logic [31:0] exp_d;
    bit          exp_e;
    bit          known;
    int          n;
    exp_e = !addr_ok(a);
    known = 1'b1;
    if (wen) begin
      model_write(u, a, wd, wm);
      exp_d = 32'h0;
    end else if (exp_e) begin
      exp_d = 32'h0;
    end else begin
      known = mdl.exists(key_of(u, a));
      exp_d = known ? mdl[key_of(u, a)] : 32'h0;
    end

    @(negedge clk);
    check("idle_rdy", 32'(req_ready[u]), 32'h1);
    req_valid[u] = 1'b1;
    req_wen[u]   = wen;
    req_addr[u]  = a;
    req_wdata[u] = wd;
    req_wmask[u] = wm;
    rsp_ready[u] = (stall == 0);
    @(posedge clk);
    @(negedge clk);
    req_valid[u] = 1'b0;
    req_wen[u]   = $urandom_range(0, 1) == 1;
    req_addr[u]  = $urandom;
    req_wdata[u] = $urandom;
    req_wmask[u] = 4'($urandom_range(0, 15));
    n = 1;
    while (!rsp_valid[u] && n < 40) begin
      check("busy_rdy", 32'(req_ready[u]), 32'h0);
      @(negedge clk);
      n++;
    end
    check("latency", 32'(n), 32'(1 + lat_of(u)));
    check("rsp_err", 32'(rsp_err[u]), 32'(exp_e));
    if (known) check("rsp_rdata", rsp_rdata[u], exp_d);
    got = rsp_rdata[u];
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid[u]), 32'h1);
      check("hold_rdata", rsp_rdata[u], got);
      check("hold_rdy", 32'(req_ready[u]), 32'h0);
    end
    rsp_ready[u] = 1'b1;
    @(negedge clk);
    check("post_valid", 32'(rsp_valid[u]), 32'h0);
    check("post_rdy", 32'(req_ready[u]), 32'h1);
    rsp_ready[u] = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] lo;
    lo = 32'($urandom_range(0, 3));
    case ($urandom_range(0, 5))
      0, 1, 2: return BASE + 32'(4 * $urandom_range(0, 7)) + lo;
      3:       return BASE + 32'(4 * (DEPTH - 1 - $urandom_range(0, 3))) + lo;
      4:       return BASE + SPAN + 32'(4 * $urandom_range(0, 3));
      default: return BASE - 32'(4 * $urandom_range(1, 4)) + lo;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    rst       = 2'b11;
    req_valid = '0;
    req_wen   = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_wmask = '0;
    rsp_ready = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rdy0", 32'(req_ready[0]), 32'h0);
    check("rst_rdy1", 32'(req_ready[1]), 32'h0);
    rst = 2'b00;
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check("rst_rdy", 32'(req_ready[u]), 32'h1);
      check("rst_valid", 32'(rsp_valid[u]), 32'h0);
      check("rst_rdata", rsp_rdata[u], 32'h0);
      check("rst_err", 32'(rsp_err[u]), 32'h0);
    end

    // known contents for every word the random phase can touch
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 8; i++)
        txn(u, 1'b1, BASE + 32'(4 * i), $urandom, 4'hF, 0, got);
      for (int i = DEPTH - 4; i < DEPTH; i++)
        txn(u, 1'b1, BASE + 32'(4 * i), $urandom, 4'hF, 0, got);
    end

    // directed scenarios on the LATENCY=2 build
    txn(0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, got);
    check("wr_rdata", got, 32'h0);
    txn(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 0, got);
    check("rd_full", got, 32'hDEAD_BEEF);
    txn(0, 1'b1, 32'h8000_0010, 32'h00AA_0000, 4'b0100, 0, got);
    txn(0, 1'b0, 32'h8000_0013, 32'h0, 4'h0, 0, got);
    check("rd_partial", got, 32'hDEAA_BEEF);
    txn(0, 1'b1, 32'h8000_0010, 32'h1234_5678, 4'h0, 0, got);
    txn(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 0, got);
    check("rd_nomask", got, 32'hDEAA_BEEF);
    txn(0, 1'b1, 32'h8000_0000, 32'h0BAD_F00D, 4'hF, 0, got);
    txn(0, 1'b1, 32'h8000_1000, 32'hFFFF_FFFF, 4'hF, 0, got);
    txn(0, 1'b0, 32'h8000_1000, 32'h0, 4'h0, 0, got);
    check("oob_rdata", got, 32'h0);
    txn(0, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 0, got);
    check("word0_kept", got, 32'h0BAD_F00D);
    txn(0, 1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, 0, got);
    txn(0, 1'b1, 32'h8000_0FFC, 32'hCAFE_0001, 4'hF, 0, got);
    txn(0, 1'b0, 32'h8000_0FFC, 32'h0, 4'h0, 5, got);
    check("top_word", got, 32'hCAFE_0001);

    // LATENCY=0 build
    txn(1, 1'b1, 32'h8000_0020, 32'h5555_AAAA, 4'hF, 0, got);
    txn(1, 1'b0, 32'h8000_0022, 32'h0, 4'h0, 3, got);
    check("l0_rd", got, 32'h5555_AAAA);

    // reset while waiting: response dropped, write stays committed
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_wen[0]   = 1'b1;
    req_addr[0]  = 32'h8000_0018;
    req_wdata[0] = 32'hA5A5_5A5A;
    req_wmask[0] = 4'hF;
    model_write(0, 32'h8000_0018, 32'hA5A5_5A5A, 4'hF);
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    rst[0] = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", 32'(rsp_valid[0]), 32'h0);
    check("mid_rst_rdy", 32'(req_ready[0]), 32'h0);
    rst[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("after_rst_valid", 32'(rsp_valid[0]), 32'h0);
      check("after_rst_rdy", 32'(req_ready[0]), 32'h1);
    end
    txn(0, 1'b0, 32'h8000_0018, 32'h0, 4'h0, 0, got);
    check("rst_write_kept", got, 32'hA5A5_5A5A);

    // random traffic against the model
    for (int it = 0; it < 300; it++) begin
      int u;
      u = $urandom_range(0, 1);
      txn(u, $urandom_range(0, 1) == 1, rand_addr(), $urandom,
          4'($urandom_range(0, 15)),
          ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0, got);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
